spi_command_queue: RTL and testbench
====================================

# spi_command_queue

Command-side front end for the SPI master in this design. Buffers outgoing SPI words from a system-side valid/ready producer in a small FIFO and launches one SPI frame per queued word through the master's `enable`/`busy` handshake. Captures the master's `incoming_data` at the end of each frame and presents it as a one-cycle response strobe. Inserts a programmable idle gap between frames so slave-select deasserts cleanly.

## Interface
- `DATA_WIDTH`, 16: width of queued command words; equals the master's `OUTGOING_DATA_WIDTH`.
- `RESP_WIDTH`, 8: width of captured response; equals the master's `INCOMING_DATA_WIDTH`.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `GAP_CYCLES`, 2: idle clocks between `busy` falling and the next `enable`; 0 is legal.

Ports (name, direction, width, meaning):
- `clk`  in  1  single system clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_data`  in  DATA_WIDTH  word to transmit.
- `cmd_valid`  in  1  producer offers `cmd_data`.
- `cmd_ready`  out  1  FIFO can accept; equals (level < DEPTH), derived from registered level.
- `level`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `spi_enable`  out  1  registered; to master `enable`.
- `spi_outgoing_data`  out  DATA_WIDTH  registered; to master `outgoing_data`.
- `spi_busy`  in  1  from master `busy`.
- `spi_incoming_data`  in  RESP_WIDTH  from master `incoming_data`.
- `resp_data`  out  RESP_WIDTH  captured response, held until the next capture.
- `resp_valid`  out  1  one-cycle strobe when `resp_data` updates.
- `idle`  out  1  high when state is IDLE and the FIFO is empty.

## Operation
- Push: a word is written when `cmd_valid && cmd_ready` at a rising edge. When full, `cmd_ready`=0 and `cmd_valid` is ignored. A pop in the same cycle does not open space until the next cycle.
- FIFO: circular, read/write pointers wrap at DEPTH. `level` tracks occupancy; push and pop in the same cycle leave `level` unchanged.
- FSM states:
  - IDLE: if `level`>0, load head word into `spi_outgoing_data`, set `spi_enable`=1, go to LAUNCH.
  - LAUNCH: hold `spi_enable`=1 until `spi_busy`=1 is sampled. On that edge, clear `spi_enable`, pop FIFO, go to WAIT_DONE.
  - WAIT_DONE: on first sampled `spi_busy`=0, capture `spi_incoming_data` into `resp_data` and pulse `resp_valid`. Go to GAP, or to IDLE if `GAP_CYCLES`=0.
  - GAP: count `GAP_CYCLES` clocks, then go to IDLE.
- `spi_outgoing_data` is stable from LAUNCH entry until the next IDLE→LAUNCH transition.
- The master must never see `enable` high while it is returning to its idle state. Clearing `enable` on the first `busy`=1 guarantees this.
- Reset (async, any state including mid-frame):
  - `spi_enable`, `resp_valid`, `level`, and pointers go to 0 immediately; FIFO is flushed.
  - `resp_data` and `spi_outgoing_data` go to 0; `cmd_ready`=1 and `idle`=1.
  - No response is produced for an interrupted frame.

## Timing
- Push at edge N: `level` updates at N. Earliest IDLE→LAUNCH is edge N+1, so `spi_enable` is high after N+1.
- Master raises `busy` one clock after seeing `enable`. `spi_enable` is therefore high for exactly 2 cycles with a compliant master.
- `busy` falls at edge B: `resp_valid` is high during the cycle after edge B+1.
- Next `spi_enable` rises at edge B+1+GAP_CYCLES+1 when the FIFO is non-empty.
- Back-to-back words already queued: no FIFO-side bubbles; frame spacing is set only by GAP_CYCLES.
- `resp_valid` is a single-cycle pulse per frame with no backpressure; the consumer must accept it.

## Test plan
- Reset mid-frame:
  - Stimulus: assert `reset_n`=0 while in WAIT_DONE with 3 words queued.
  - Response: `spi_enable`=0 without waiting for a clock edge; `level`=0, `idle`=1, no `resp_valid` after release.
- Single word:
  - Stimulus: push 16'hA5C3, with a master model that raises `busy` for 40 cycles and returns 8'h5A.
  - Response: `spi_outgoing_data`=16'hA5C3; `spi_enable` high for exactly 2 cycles; one `resp_valid` pulse with `resp_data`=8'h5A; `idle`=1 afterwards.
- Fill and overflow:
  - Stimulus: hold `spi_busy`=1 and push 10 words 16'h0001..16'h000A.
  - Response: `cmd_ready`=0 once `level`=8; words 9 and 10 are not accepted; the frames launched later send 0001..0008 in order.
- Back-to-back spacing:
  - Stimulus: queue 4 words with GAP_CYCLES=2.
  - Response: 4 `resp_valid` pulses in order; each `enable` rise is exactly 4 clocks after the previous `busy` falling edge.
- Simultaneous push and pop at full:
  - Stimulus: FIFO full, pop on LAUNCH→WAIT_DONE while `cmd_valid`=1.
  - Response: push is refused that cycle; `level`=7 next cycle and the push is accepted one cycle later.
- GAP_CYCLES=0 plus pointer wrap:
  - Stimulus: stream 20 words through DEPTH=8.
  - Response: all 20 responses in order; pointer wrap is transparent; `level` never exceeds 8.

Source files
------------

// File: rtl/spi_command_queue.sv
// rtl/spi_command_queue.sv - SPI command FIFO, frame launcher and response capture
module spi_command_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int RESP_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   spi_enable,
  output logic [DATA_WIDTH-1:0]  spi_outgoing_data,
  input  logic                   spi_busy,
  input  logic [RESP_WIDTH-1:0]  spi_incoming_data,
  output logic [RESP_WIDTH-1:0]  resp_data,
  output logic                   resp_valid,
  output logic                   idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [GW-1:0]          gap_cnt;
  logic                   push;
  logic                   pop;
  logic                   launch;
  logic                   capture;

  // Space is judged from the registered level, so a pop only frees a slot on the following cycle.
  assign cmd_ready = (level < LEVEL_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign idle      = (state_q == ST_IDLE) && (level == '0);

  // FIFO storage; stale contents after reset are harmless because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_data;
    end
  end

  // Circular pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one frame per queued word, then an optional idle gap so slave-select can settle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (level != '0) state_d = ST_LAUNCH;
      ST_LAUNCH:    if (spi_busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!spi_busy) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:       if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode: enable is dropped on the first busy so the master never sees it while returning idle.
  always_comb begin
    launch  = 1'b0;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE:      launch  = (level != '0);
      ST_LAUNCH:    pop     = spi_busy;
      ST_WAIT_DONE: capture = !spi_busy;
      default:      ;
    endcase
  end

  // Registered master-facing outputs, response capture and gap counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_enable        <= 1'b0;
      spi_outgoing_data <= '0;
      resp_valid        <= 1'b0;
      resp_data         <= '0;
      gap_cnt           <= '0;
    end else begin
      resp_valid <= capture;
      if (launch) begin
        spi_enable        <= 1'b1;
        spi_outgoing_data <= mem[rd_ptr];
      end else if (pop) begin
        spi_enable <= 1'b0;
      end
      if (capture) begin
        resp_data <= spi_incoming_data;
      end
      if (state_q == ST_GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_command_queue.sv
// tb/tb_spi_command_queue.sv - scoreboard bench for spi_command_queue
module tb_spi_command_queue;

  localparam int DW   = 16;
  localparam int RW   = 8;
  localparam int LW   = 4;
  localparam int NLOG = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: GAP_CYCLES=2, index 1: GAP_CYCLES=0
  logic [DW-1:0] cmd_data   [2];
  logic          cmd_valid  [2];
  logic          cmd_ready  [2];
  logic [LW-1:0] level      [2];
  logic          spi_enable [2];
  logic [DW-1:0] spi_out    [2];
  logic          spi_busy   [2];
  logic [RW-1:0] spi_in     [2];
  logic [RW-1:0] resp_data  [2];
  logic          resp_valid [2];
  logic          idle       [2];

  int   busy_len  [2];
  int   busy_cnt  [2];
  logic hold_busy [2];

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_tx  [$];
  logic [RW-1:0] exp_rsp [$];

  spi_command_queue #(.DATA_WIDTH(DW), .RESP_WIDTH(RW), .DEPTH(8), .GAP_CYCLES(2)) u_dut_gap2 (
    .clk(clk), .reset_n(reset_n),
    .cmd_data(cmd_data[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .level(level[0]),
    .spi_enable(spi_enable[0]), .spi_outgoing_data(spi_out[0]),
    .spi_busy(spi_busy[0]), .spi_incoming_data(spi_in[0]),
    .resp_data(resp_data[0]), .resp_valid(resp_valid[0]), .idle(idle[0])
  );

  spi_command_queue #(.DATA_WIDTH(DW), .RESP_WIDTH(RW), .DEPTH(8), .GAP_CYCLES(0)) u_dut_gap0 (
    .clk(clk), .reset_n(reset_n),
    .cmd_data(cmd_data[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .level(level[1]),
    .spi_enable(spi_enable[1]), .spi_outgoing_data(spi_out[1]),
    .spi_busy(spi_busy[1]), .spi_incoming_data(spi_in[1]),
    .resp_data(resp_data[1]), .resp_valid(resp_valid[1]), .idle(idle[1])
  );

  function automatic logic [RW-1:0] resp_of(input logic [DW-1:0] w);
    return w[15:8] ^ w[7:0] ^ 8'h3C;
  endfunction

  // master model: busy one clock after enable, held busy_len clocks, or held while hold_busy
  always @(posedge clk or negedge reset_n) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset_n) begin
        spi_busy[g] <= 1'b0;
        busy_cnt[g] <= 0;
        spi_in[g]   <= '0;
      end else if (hold_busy[g]) begin
        spi_busy[g] <= 1'b1;
        busy_cnt[g] <= 0;
        if (spi_enable[g]) spi_in[g] <= resp_of(spi_out[g]);
      end else if (spi_busy[g]) begin
        if (busy_cnt[g] <= 1) spi_busy[g] <= 1'b0;
        else busy_cnt[g] <= busy_cnt[g] - 1;
      end else if (spi_enable[g]) begin
        spi_busy[g] <= 1'b1;
        busy_cnt[g] <= busy_len[g];
        spi_in[g]   <= resp_of(spi_out[g]);
      end
    end
  end

  logic [DW-1:0] tx_log   [2][NLOG];
  int            rise_cyc [2][NLOG];
  int            en_len   [2][NLOG];
  logic [RW-1:0] rsp_log  [2][NLOG];
  int            rsp_cyc  [2][NLOG];
  int            fall_cyc [2][NLOG];
  int            tx_n [2], rsp_n [2], fall_n [2], en_run [2];
  logic          prev_en [2], prev_busy [2];
  logic [LW-1:0] max_lvl [2];

  // observation log, sampled on the falling edge
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset_n) begin
        tx_n[g] = 0; rsp_n[g] = 0; fall_n[g] = 0; en_run[g] = 0;
        prev_en[g] = 1'b0; prev_busy[g] = 1'b0; max_lvl[g] = '0;
      end else begin
        if (spi_enable[g] && !prev_en[g]) begin
          if (tx_n[g] < NLOG) begin
            tx_log[g][tx_n[g]]   = spi_out[g];
            rise_cyc[g][tx_n[g]] = cyc;
          end
          tx_n[g]   = tx_n[g] + 1;
          en_run[g] = 0;
        end
        if (spi_enable[g]) en_run[g] = en_run[g] + 1;
        else if (prev_en[g] && tx_n[g] <= NLOG) en_len[g][tx_n[g]-1] = en_run[g];
        if (prev_busy[g] && !spi_busy[g]) begin
          if (fall_n[g] < NLOG) fall_cyc[g][fall_n[g]] = cyc;
          fall_n[g] = fall_n[g] + 1;
        end
        if (resp_valid[g]) begin
          if (rsp_n[g] < NLOG) begin
            rsp_log[g][rsp_n[g]] = resp_data[g];
            rsp_cyc[g][rsp_n[g]] = cyc;
          end
          rsp_n[g] = rsp_n[g] + 1;
        end
        if (level[g] > max_lvl[g]) max_lvl[g] = level[g];
        prev_en[g]   = spi_enable[g];
        prev_busy[g] = spi_busy[g];
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      cmd_valid[g] = 1'b0;
      cmd_data[g]  = '0;
      hold_busy[g] = 1'b0;
    end
    exp_tx.delete();
    exp_rsp.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int g, input logic [DW-1:0] d, output logic acc);
    cmd_data[g]  = d;
    cmd_valid[g] = 1'b1;
    acc = cmd_ready[g];
    @(posedge clk);
    #1;
    cmd_valid[g] = 1'b0;
    if (acc) begin
      exp_tx.push_back(d);
      exp_rsp.push_back(resp_of(d));
    end
  endtask

  task automatic wait_rsp(input int g, input int n, input int budget, output logic ok);
    for (int i = 0; i < budget && rsp_n[g] < n; i++) @(posedge clk);
    #1;
    ok = (rsp_n[g] >= n);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (level[0] !== 4'd0)     begin bad++; $display("FAIL reset_level got=%0d want=0", level[0]); end
    total++; if (cmd_ready[0] !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready[0]); end
    total++; if (idle[0] !== 1'b1)      begin bad++; $display("FAIL reset_idle got=%b want=1", idle[0]); end
    total++; if (spi_enable[0] !== 1'b0) begin bad++; $display("FAIL reset_enable got=%b want=0", spi_enable[0]); end
    total++; if (resp_valid[0] !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid[0]); end
    total++; if (resp_data[0] !== 8'h00) begin bad++; $display("FAIL reset_resp_data got=%h want=00", resp_data[0]); end
    total++; if (spi_out[0] !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", spi_out[0]); end
    total++; if (idle[1] !== 1'b1)      begin bad++; $display("FAIL reset_idle_gap0 got=%b want=1", idle[1]); end
  endtask

  task automatic test_single_word();
    logic acc, ok;
    int pc;
    logic [DW-1:0] et;
    logic [RW-1:0] er;
    apply_reset();
    busy_len[0] = 40;
    push_word(0, 16'hA5C3, acc);
    pc = cyc;
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_accept got=%b want=1", acc); end
    wait_rsp(0, 1, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout got=%0d responses want=1", rsp_n[0]); end
    repeat (10) @(posedge clk);
    #1;
    et = exp_tx.pop_front();
    er = exp_rsp.pop_front();
    total++; if (tx_n[0] !== 1)          begin bad++; $display("FAIL single_frames got=%0d want=1", tx_n[0]); end
    total++; if (tx_log[0][0] !== et)    begin bad++; $display("FAIL single_tx got=%h want=%h", tx_log[0][0], et); end
    total++; if (spi_out[0] !== et)      begin bad++; $display("FAIL single_out_hold got=%h want=%h", spi_out[0], et); end
    total++; if (en_len[0][0] !== 2)     begin bad++; $display("FAIL single_enable_len got=%0d want=2", en_len[0][0]); end
    total++; if (rise_cyc[0][0] - pc !== 1) begin bad++; $display("FAIL single_launch_lat got=%0d want=1", rise_cyc[0][0] - pc); end
    total++; if (rsp_n[0] !== 1)         begin bad++; $display("FAIL single_pulses got=%0d want=1", rsp_n[0]); end
    total++; if (rsp_log[0][0] !== er)   begin bad++; $display("FAIL single_resp got=%h want=%h", rsp_log[0][0], er); end
    total++; if (resp_data[0] !== 8'h5A) begin bad++; $display("FAIL single_resp_hold got=%h want=5a", resp_data[0]); end
    total++; if (rsp_cyc[0][0] - fall_cyc[0][0] !== 1) begin bad++; $display("FAIL single_resp_lat got=%0d want=1", rsp_cyc[0][0] - fall_cyc[0][0]); end
    total++; if (idle[0] !== 1'b1)       begin bad++; $display("FAIL single_idle_after got=%b want=1", idle[0]); end
  endtask

  task automatic test_back_to_back();
    logic acc, ok;
    logic [DW-1:0] words [4];
    logic [DW-1:0] et;
    logic [RW-1:0] er;
    apply_reset();
    busy_len[0] = 5;
    words = '{16'h1357, 16'h2468, 16'hFFFF, 16'h8001};
    for (int i = 0; i < 4; i++) push_word(0, words[i], acc);
    wait_rsp(0, 4, 300, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=%0d responses want=4", rsp_n[0]); end
    for (int k = 0; k < 4; k++) begin
      et = exp_tx.pop_front();
      er = exp_rsp.pop_front();
      total++; if (tx_log[0][k] !== et)  begin bad++; $display("FAIL b2b_tx[%0d] got=%h want=%h", k, tx_log[0][k], et); end
      total++; if (rsp_log[0][k] !== er) begin bad++; $display("FAIL b2b_resp[%0d] got=%h want=%h", k, rsp_log[0][k], er); end
      total++; if (rsp_cyc[0][k] - fall_cyc[0][k] !== 1) begin bad++; $display("FAIL b2b_resp_lat[%0d] got=%0d want=1", k, rsp_cyc[0][k] - fall_cyc[0][k]); end
      if (k > 0) begin
        total++; if (rise_cyc[0][k] - fall_cyc[0][k-1] !== 4) begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=4", k, rise_cyc[0][k] - fall_cyc[0][k-1]); end
      end
    end
  endtask

  task automatic test_fill_overflow();
    logic acc;
    int i;
    apply_reset();
    busy_len[0]  = 3;
    hold_busy[0] = 1'b1;
    push_word(0, 16'h0F0F, acc);
    for (i = 0; i < 20 && level[0] != 4'd0; i++) begin
      @(posedge clk);
      #1;
    end
    total++; if (level[0] !== 4'd0) begin bad++; $display("FAIL fill_first_pop got=%0d want=0", level[0]); end
    for (int w = 1; w <= 10; w++) begin
      push_word(0, DW'(w), acc);
      total++; if (acc !== (w <= 8)) begin bad++; $display("FAIL fill_accept[%0d] got=%b want=%b", w, acc, (w <= 8)); end
    end
    total++; if (level[0] !== 4'd8)     begin bad++; $display("FAIL fill_level got=%0d want=8", level[0]); end
    total++; if (cmd_ready[0] !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", cmd_ready[0]); end
  endtask

  task automatic test_full_push_pop();
    logic ok;
    logic [DW-1:0] et;
    logic [RW-1:0] er;
    int n;
    cmd_data[0]  = 16'h000B;
    cmd_valid[0] = 1'b1;
    hold_busy[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (level[0] != 4'd8) break;
    end
    total++; if (level[0] !== 4'd7)     begin bad++; $display("FAIL fullpp_refused got=%0d want=7", level[0]); end
    total++; if (cmd_ready[0] !== 1'b1) begin bad++; $display("FAIL fullpp_ready got=%b want=1", cmd_ready[0]); end
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    total++; if (level[0] !== 4'd8)     begin bad++; $display("FAIL fullpp_accepted got=%0d want=8", level[0]); end
    exp_tx.push_back(16'h000B);
    exp_rsp.push_back(resp_of(16'h000B));
    n = exp_tx.size();
    wait_rsp(0, n, 600, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL fullpp_timeout got=%0d responses want=%0d", rsp_n[0], n); end
    total++; if (tx_n[0] !== n) begin bad++; $display("FAIL fullpp_frames got=%0d want=%0d", tx_n[0], n); end
    for (int k = 0; k < n && k < NLOG; k++) begin
      et = exp_tx.pop_front();
      er = exp_rsp.pop_front();
      total++; if (tx_log[0][k] !== et)  begin bad++; $display("FAIL fullpp_tx[%0d] got=%h want=%h", k, tx_log[0][k], et); end
      total++; if (rsp_log[0][k] !== er) begin bad++; $display("FAIL fullpp_resp[%0d] got=%h want=%h", k, rsp_log[0][k], er); end
    end
  endtask

  task automatic test_gap0_wrap();
    logic acc, ok;
    logic [DW-1:0] d;
    logic [DW-1:0] et;
    logic [RW-1:0] er;
    int tries;
    apply_reset();
    busy_len[1] = 3;
    for (int i = 0; i < 20; i++) begin
      d = DW'(32'h1000 + i * 32'h123);
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 50) begin
        push_word(1, d, acc);
        tries++;
      end
      if (!acc) begin
        total++; bad++;
        $display("FAIL gap0_push_stall got=refused want=accepted word=%0d", i);
      end
    end
    wait_rsp(1, 20, 1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL gap0_timeout got=%0d responses want=20", rsp_n[1]); end
    total++; if (max_lvl[1] !== 4'd8) begin bad++; $display("FAIL gap0_max_level got=%0d want=8", max_lvl[1]); end
    for (int k = 0; k < 20; k++) begin
      et = exp_tx.pop_front();
      er = exp_rsp.pop_front();
      total++; if (tx_log[1][k] !== et)  begin bad++; $display("FAIL gap0_tx[%0d] got=%h want=%h", k, tx_log[1][k], et); end
      total++; if (rsp_log[1][k] !== er) begin bad++; $display("FAIL gap0_resp[%0d] got=%h want=%h", k, rsp_log[1][k], er); end
      if (k > 0) begin
        total++; if (rise_cyc[1][k] - fall_cyc[1][k-1] !== 2) begin bad++; $display("FAIL gap0_spacing[%0d] got=%0d want=2", k, rise_cyc[1][k] - fall_cyc[1][k-1]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic acc;
    int i;
    apply_reset();
    busy_len[0] = 40;
    for (int w = 0; w < 4; w++) push_word(0, DW'(16'hD000 + w), acc);
    for (i = 0; i < 30 && !(level[0] == 4'd3 && spi_busy[0] && !spi_enable[0]); i++) begin
      @(posedge clk);
      #1;
    end
    total++; if (level[0] !== 4'd3) begin bad++; $display("FAIL midrst_setup got=%0d want=3", level[0]); end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (level[0] !== 4'd0)     begin bad++; $display("FAIL midrst_level got=%0d want=0", level[0]); end
    total++; if (idle[0] !== 1'b1)      begin bad++; $display("FAIL midrst_idle got=%b want=1", idle[0]); end
    total++; if (cmd_ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", cmd_ready[0]); end
    total++; if (spi_out[0] !== 16'h0000) begin bad++; $display("FAIL midrst_out_data got=%h want=0000", spi_out[0]); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_tx.delete();
    exp_rsp.delete();
    @(posedge clk);
    #1;
    push_word(0, 16'hC0DE, acc);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (spi_enable[0]) break;
    end
    #2;
    total++; if (spi_enable[0] !== 1'b1) begin bad++; $display("FAIL launchrst_setup got=%b want=1", spi_enable[0]); end
    reset_n = 1'b0;
    #1;
    total++; if (spi_enable[0] !== 1'b0) begin bad++; $display("FAIL launchrst_enable got=%b want=0", spi_enable[0]); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    total++; if (rsp_n[0] !== 0)    begin bad++; $display("FAIL midrst_no_resp got=%0d want=0", rsp_n[0]); end
    total++; if (tx_n[0] !== 0)     begin bad++; $display("FAIL midrst_no_frame got=%0d want=0", tx_n[0]); end
    total++; if (idle[0] !== 1'b1)  begin bad++; $display("FAIL midrst_idle_after got=%b want=1", idle[0]); end
    total++; if (resp_data[0] !== 8'h00) begin bad++; $display("FAIL midrst_resp_data got=%h want=00", resp_data[0]); end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      cmd_valid[g] = 1'b0;
      cmd_data[g]  = '0;
      hold_busy[g] = 1'b0;
      busy_len[g]  = 4;
    end
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fill_overflow();
    test_full_push_pop();
    test_gap0_wrap();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
